// File: rtl/router_rr_drain_pkg.sv
// router_rr_drain_pkg: shared encodings and header-field constants for the round-robin FIFO drain block
package router_rr_drain_pkg;

  localparam int NUM_CHAN = 3;

  // Packet header layout: LEN payload-byte count lives in header[5:2]
  localparam int LEN_MSB = 5;
  localparam int LEN_LSB = 2;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Channel index modulo the channel count, used for wrap-around round-robin search
  function automatic logic [1:0] chan_wrap(input int idx);
    return 2'(idx % NUM_CHAN);
  endfunction

endpackage

// File: rtl/router_rr_drain_pick3.sv
// rr_pick3: combinational 3-way round-robin picker, searching from the channel after last_grant
module rr_pick3
  import router_rr_drain_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant,
  output logic       any
);

  // Walk the channels starting just after the previous winner and take the first requester
  always_comb begin
    grant = 2'd0;
    any   = 1'b0;
    for (int i = 1; i <= NUM_CHAN; i++) begin
      if (!any && req[chan_wrap(int'(last_grant) + i)]) begin
        grant = chan_wrap(int'(last_grant) + i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_rr_drain.sv
// router_rr_drain: drains three router FIFOs packet-by-packet onto one registered valid/ready byte
// stream, with round-robin packet grants and a starvation timeout that abandons a stuck packet
module router_rr_drain
  import router_rr_drain_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] chan_en,
  input  logic [2:0] vldout,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic [2:0] read_enb,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_chan,
  output logic       out_last,
  output logic       timeout_err
);

  localparam int            SW           = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(TIMEOUT_CYC);

  state_t           state;
  state_t           state_next;
  logic [1:0]       gnt;
  logic [1:0]       last_grant;
  logic [1:0]       pick_grant;
  logic             pick_any;
  logic [2:0]       req_mask;
  logic             hdr_done;
  logic [LEN_W-1:0] remaining;
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_next;
  logic [7:0]       head;
  logic             vld_g;
  logic             slot_free;
  logic             pop;
  logic             pop_last;
  logic             starve_hit;

  assign req_mask = vldout & chan_en;

  rr_pick3 u_pick (
    .req        (req_mask),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  // Pop strobes are held off while reset is low so a mid-packet reset loses no FIFO data
  assign read_enb = (pop && rst_n) ? 3'(3'b001 << gnt) : 3'b000;

  // Next-state and pop decisions: pop when the granted FIFO has data and the output slot can take it
  always_comb begin
    state_next  = state;
    head        = data_out_0;
    vld_g       = 1'b0;
    slot_free   = !out_valid || out_ready;
    pop         = 1'b0;
    pop_last    = 1'b0;
    starve_hit  = 1'b0;
    starve_next = starve_cnt;
    case (gnt)
      2'd0: begin
        head  = data_out_0;
        vld_g = vldout[0];
      end
      2'd1: begin
        head  = data_out_1;
        vld_g = vldout[1];
      end
      2'd2: begin
        head  = data_out_2;
        vld_g = vldout[2];
      end
      default: begin
        head  = data_out_0;
        vld_g = 1'b0;
      end
    endcase
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (vld_g && slot_free) begin
          pop         = 1'b1;
          pop_last    = hdr_done ? (remaining == LEN_W'(1))
                                 : (head[LEN_MSB:LEN_LSB] == '0);
          starve_next = '0;
          if (pop_last) begin
            state_next = ST_IDLE;
          end
        end else if (!vld_g) begin
          starve_next = starve_cnt + SW'(1);
          if (starve_next == STARVE_LIMIT) begin
            starve_hit = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register plus grant bookkeeping; last_grant only moves when a packet ends or is abandoned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= 2'd0;
      last_grant <= 2'd2;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && pick_any) begin
        gnt <= pick_grant;
      end
      if (pop_last || starve_hit) begin
        last_grant <= gnt;
      end
    end
  end

  // Packet progress: header pop loads the payload count, payload pops count it down, idle clears all
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_done   <= 1'b0;
      remaining  <= '0;
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      hdr_done   <= 1'b0;
      remaining  <= '0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_hit ? '0 : starve_next;
      if (pop) begin
        if (!hdr_done) begin
          hdr_done  <= 1'b1;
          remaining <= head[LEN_MSB:LEN_LSB];
        end else begin
          remaining <= remaining - LEN_W'(1);
        end
      end
    end
  end

  // Output slot: a popped byte lands here one cycle later and stays until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_chan    <= 2'd0;
      out_last    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= starve_hit;
      if (pop) begin
        out_data  <= head;
        out_chan  <= gnt;
        out_last  <= pop_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_rr_drain.sv
// tb_router_rr_drain: scenario tasks plus a randomized packet-level round-robin reference model
module tb_router_rr_drain;

  localparam int TIMEOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] chan_en;
  logic [2:0] vldout;
  logic [7:0] data_out_0;
  logic [7:0] data_out_1;
  logic [7:0] data_out_2;
  logic [2:0] read_enb;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_chan;
  logic       out_last;
  logic       timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  logic [7:0]  m0[$];
  logic [7:0]  m1[$];
  logic [7:0]  m2[$];
  logic [10:0] exp_beats[$];
  logic [2:0]  re_cap = 3'b000;
  logic [2:0]  hold = 3'b000;

  router_rr_drain #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chan_en     (chan_en),
    .vldout      (vldout),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .data_out_2  (data_out_2),
    .read_enb    (read_enb),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_chan    (out_chan),
    .out_last    (out_last),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Pop strobes are captured mid-cycle, then applied to the FIFO model just after the next edge
  always @(negedge clk) re_cap = read_enb;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic refresh();
    vldout[0]  = (q0.size() > 0) && !hold[0];
    vldout[1]  = (q1.size() > 0) && !hold[1];
    vldout[2]  = (q2.size() > 0) && !hold[2];
    data_out_0 = (q0.size() > 0) ? q0[0] : 8'h00;
    data_out_1 = (q1.size() > 0) ? q1[0] : 8'h00;
    data_out_2 = (q2.size() > 0) ? q2[0] : 8'h00;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (re_cap[0] && q0.size() > 0) q0.delete(0);
    if (re_cap[1] && q1.size() > 0) q1.delete(0);
    if (re_cap[2] && q2.size() > 0) q2.delete(0);
    refresh();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    hold      = 3'b000;
    chan_en   = 3'b111;
    out_ready = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    refresh();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic push_both(input int c, input logic [7:0] b);
    case (c)
      0: begin q0.push_back(b); m0.push_back(b); end
      1: begin q1.push_back(b); m1.push_back(b); end
      default: begin q2.push_back(b); m2.push_back(b); end
    endcase
  endtask

  function automatic int msize(input int c);
    case (c)
      0: return m0.size();
      1: return m1.size();
      default: return m2.size();
    endcase
  endfunction

  function automatic logic [7:0] mpop(input int c);
    case (c)
      0: return m0.pop_front();
      1: return m1.pop_front();
      default: return m2.pop_front();
    endcase
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    chan_en   = 3'b111;
    out_ready = 1'b1;
    hold      = 3'b000;
    q0.delete();
    q1.delete();
    q2.delete();
    q0.push_back(8'h00);
    refresh();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if (out_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_out_data got %h want 00", out_data); end
    n_cmp++;
    if (out_chan !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_out_chan got %0d want 0", out_chan); end
    n_cmp++;
    if (out_last !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_last got %b want 0", out_last); end
    n_cmp++;
    if (timeout_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_timeout got %b want 0", timeout_err); end
    n_cmp++;
    if (read_enb !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_read_enb got %b want 000", read_enb); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [7:0] bd [3];
    logic [1:0] bc [3];
    logic       bl [3];
    int         bt [3];
    logic [7:0] want_d [3];
    int         nb;
    want_d = '{8'h08, 8'hAA, 8'hBB};
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      bd[i] = 8'h00; bc[i] = 2'd0; bl[i] = 1'b0; bt[i] = -1;
    end
    do_reset();
    q1.push_back(8'h08);
    q1.push_back(8'hAA);
    q1.push_back(8'hBB);
    refresh();
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (nb < 3) begin
          bd[nb] = out_data; bc[nb] = out_chan; bl[nb] = out_last; bt[nb] = t;
        end
        nb++;
      end
      next_cycle();
    end
    n_cmp++;
    if (nb != 3) begin n_bad++; $display("[TB] FAIL single_count got %0d want 3", nb); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bd[i] !== want_d[i] || bc[i] !== 2'd1 || bl[i] !== (i == 2) || bt[i] != 2 + i)
        begin
        n_bad++;
        $display("[TB] FAIL single_beat%0d got data=%h chan=%0d last=%b cyc=%0d want data=%h chan=1 last=%b cyc=%0d",
                 i, bd[i], bc[i], bl[i], bt[i], want_d[i], (i == 2), 2 + i);
      end
    end
  endtask

  task automatic test_rr_order();
    logic [1:0] oc [5];
    logic [7:0] od [5];
    logic [1:0] want_c [5];
    logic [7:0] want_d [5];
    int         nb;
    bit         refill_now;
    bit         refilled;
    want_c = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    want_d = '{8'h01, 8'h02, 8'h03, 8'h40, 8'h80};
    nb = 0;
    refill_now = 1'b0;
    refilled = 1'b0;
    for (int i = 0; i < 5; i++) begin oc[i] = 2'd3; od[i] = 8'hFF; end
    do_reset();
    q0.push_back(8'h01);
    q1.push_back(8'h02);
    q2.push_back(8'h03);
    refresh();
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (read_enb[1] && !refilled) refill_now = 1'b1;
      if (out_valid && out_ready) begin
        if (nb < 5) begin oc[nb] = out_chan; od[nb] = out_data; end
        nb++;
      end
      next_cycle();
      if (refill_now && !refilled) begin
        q0.push_back(8'h40);
        q1.push_back(8'h80);
        refresh();
        refilled = 1'b1;
      end
    end
    n_cmp++;
    if (nb != 5) begin n_bad++; $display("[TB] FAIL rr_count got %0d want 5", nb); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (oc[i] !== want_c[i] || od[i] !== want_d[i]) begin
        n_bad++;
        $display("[TB] FAIL rr_order%0d got chan=%0d data=%h want chan=%0d data=%h",
                 i, oc[i], od[i], want_c[i], want_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want_d [3];
    logic [7:0] gd [3];
    logic       gl [3];
    int         nb;
    bit         found;
    int         terr;
    want_d = '{8'h22, 8'h33, 8'h44};
    nb = 0;
    found = 1'b0;
    terr = 0;
    for (int i = 0; i < 3; i++) begin gd[i] = 8'h00; gl[i] = 1'b0; end
    do_reset();
    q0.push_back(8'h10);
    q0.push_back(8'h11);
    q0.push_back(8'h22);
    q0.push_back(8'h33);
    q0.push_back(8'h44);
    refresh();
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_data == 8'h11) found = 1'b1;
      next_cycle();
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("[TB] FAIL bp_reach_payload got none want data 11 within 20 cycles"); end
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h22) begin
        n_bad++;
        $display("[TB] FAIL bp_hold%0d got valid=%b data=%h want valid=1 data=22", t, out_valid, out_data);
      end
      n_cmp++;
      if (read_enb !== 3'b000 || timeout_err !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL bp_quiet%0d got read_enb=%b timeout=%b want 000 0", t, read_enb, timeout_err);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (timeout_err) terr++;
      if (out_valid && out_ready) begin
        if (nb < 3) begin gd[nb] = out_data; gl[nb] = out_last; end
        nb++;
      end
      next_cycle();
    end
    n_cmp++;
    if (nb != 3 || terr != 0) begin
      n_bad++;
      $display("[TB] FAIL bp_tail_count got beats=%0d timeouts=%0d want 3 0", nb, terr);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (gd[i] !== want_d[i] || gl[i] !== (i == 2)) begin
        n_bad++;
        $display("[TB] FAIL bp_tail%0d got data=%h last=%b want data=%h last=%b", i, gd[i], gl[i], want_d[i], (i == 2));
      end
    end
  endtask

  task automatic test_timeout();
    int         n2pops;
    int         k;
    int         tpulses;
    int         tfirst;
    int         gfirst;
    logic [2:0] gval;
    int         last2;
    bit         pushed;
    n2pops = 0; k = -1; tpulses = 0; tfirst = -1; gfirst = -1; gval = 3'b000;
    last2 = 0; pushed = 1'b0;
    do_reset();
    q2.push_back(8'h0C);
    q2.push_back(8'h77);
    refresh();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (k >= 0) k++;
      if (read_enb[2]) begin
        n2pops++;
        if (n2pops == 2) k = 0;
      end
      if (timeout_err) begin
        tpulses++;
        if (tfirst < 0) tfirst = k;
      end
      if (k > 0 && read_enb != 3'b000 && gfirst < 0) begin
        gfirst = k;
        gval = read_enb;
      end
      if (out_valid && out_ready && out_chan == 2'd2 && out_last) last2++;
      next_cycle();
      if (k == 0 && !pushed) begin
        q0.push_back(8'h00);
        refresh();
        pushed = 1'b1;
      end
    end
    n_cmp++;
    if (tpulses != 1) begin n_bad++; $display("[TB] FAIL to_pulses got %0d want 1", tpulses); end
    n_cmp++;
    if (tfirst != TIMEOUT_CYC + 1) begin
      n_bad++;
      $display("[TB] FAIL to_when got %0d want %0d", tfirst, TIMEOUT_CYC + 1);
    end
    n_cmp++;
    if (gfirst != TIMEOUT_CYC + 2 || gval !== 3'b001) begin
      n_bad++;
      $display("[TB] FAIL to_next_grant got cyc=%0d read_enb=%b want cyc=%0d read_enb=001",
               gfirst, gval, TIMEOUT_CYC + 2);
    end
    n_cmp++;
    if (last2 != 0) begin n_bad++; $display("[TB] FAIL to_no_last got %0d want 0", last2); end
  endtask

  task automatic test_mask_and_reset();
    int  g1;
    int  c1;
    int  nbeat;
    bit  found;
    int  sz;
    g1 = 0; c1 = 0; nbeat = 0; found = 1'b0;
    do_reset();
    chan_en = 3'b101;
    q0.push_back(8'h04);
    q0.push_back(8'hA0);
    q0.push_back(8'h00);
    q1.push_back(8'h00);
    q2.push_back(8'h00);
    refresh();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (read_enb[1]) g1++;
      if (out_valid && out_ready) begin
        nbeat++;
        if (out_chan == 2'd1) c1++;
      end
      next_cycle();
      out_ready = ($urandom_range(0, 1) == 1);
    end
    n_cmp++;
    if (g1 != 0 || c1 != 0) begin
      n_bad++;
      $display("[TB] FAIL mask_ch1 got pops=%0d beats=%0d want 0 0", g1, c1);
    end
    n_cmp++;
    if (nbeat != 4 || q1.size() != 1) begin
      n_bad++;
      $display("[TB] FAIL mask_drain got beats=%0d ch1_left=%0d want 4 1", nbeat, q1.size());
    end
    out_ready = 1'b1;
    chan_en   = 3'b111;
    q0.push_back(8'h3C);
    for (int i = 1; i <= 15; i++) q0.push_back(8'(i));
    refresh();
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (read_enb[0] && out_valid && out_chan == 2'd0) found = 1'b1;
      next_cycle();
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("[TB] FAIL midrst_reach got none want ch0 mid-packet within 40 cycles"); end
    rst_n = 1'b0;
    sz = q0.size();
    @(negedge clk);
    n_cmp++;
    if (read_enb !== 3'b000) begin n_bad++; $display("[TB] FAIL midrst_pop got %b want 000", read_enb); end
    next_cycle();
    n_cmp++;
    if (q0.size() != sz) begin n_bad++; $display("[TB] FAIL midrst_fifo got %0d want %0d", q0.size(), sz); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 || out_last !== 1'b0 ||
        timeout_err !== 1'b0 || read_enb !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL midrst_outputs got v=%b d=%h c=%0d l=%b t=%b re=%b want all zero",
               out_valid, out_data, out_chan, out_last, timeout_err, read_enb);
    end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int          npk;
    int          len;
    int          last;
    int          c;
    logic [7:0]  h;
    logic [10:0] got;
    logic [10:0] want;
    do_reset();
    m0.delete();
    m1.delete();
    m2.delete();
    exp_beats.delete();
    for (int ch = 0; ch < 3; ch++) begin
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(0, 15);
        h = {2'($urandom_range(0, 3)), 4'(len), 2'($urandom_range(0, 3))};
        push_both(ch, h);
        for (int j = 0; j < len; j++) push_both(ch, 8'($urandom_range(0, 255)));
      end
    end
    refresh();
    // Packet-level reference: whole packets granted round-robin from the channel after the last one
    last = 2;
    while (m0.size() > 0 || m1.size() > 0 || m2.size() > 0) begin
      c = -1;
      for (int i = 1; i <= 3; i++) begin
        if (c < 0 && msize((last + i) % 3) > 0) c = (last + i) % 3;
      end
      h = mpop(c);
      len = int'(h[5:2]);
      exp_beats.push_back({2'(c), 1'(len == 0), h});
      for (int j = 1; j <= len; j++) exp_beats.push_back({2'(c), 1'(j == len), mpop(c)});
      last = c;
    end
    for (int t = 0; t < 3000 && exp_beats.size() > 0; t++) begin
      @(negedge clk);
      n_cmp++;
      if (!$onehot0(read_enb) || (read_enb & ~vldout) != 3'b000 || timeout_err !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL rand_strobe got read_enb=%b vldout=%b timeout=%b want onehot0 subset 0",
                 read_enb, vldout, timeout_err);
      end
      if (out_valid && out_ready) begin
        got  = {out_chan, out_last, out_data};
        want = exp_beats.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("[TB] FAIL rand_beat got chan=%0d last=%b data=%h want chan=%0d last=%b data=%h",
                   got[10:9], got[8], got[7:0], want[10:9], want[8], want[7:0]);
        end
      end
      next_cycle();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    n_cmp++;
    if (exp_beats.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL rand_leftover got %0d beats outstanding want 0", exp_beats.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_rr_order();
    test_backpressure();
    test_timeout();
    test_mask_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_rr_drain.md
ROUTER_RR_DRAIN -- requirements
Module: router_rr_drain

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning consecutive starved cycles mid-packet before abort.
REQ-002 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port chan_en  input  3  per-channel grant enable; 0 masks that channel from new grants.
REQ-005 The block SHALL have port vldout  input  3  router FIFO non-empty flags, channel 2..0.
REQ-006 The block SHALL have ports data_out_0/1/2  input  8 each  router FIFO heads, first-word-fall-through.
REQ-007 The block SHALL have port read_enb  output  3  one-hot-or-zero FIFO pop strobes to the router.
REQ-008 The block SHALL have port out_data  output  8  registered merged byte stream.
REQ-009 The block SHALL have ports out_valid  output  1  and out_ready  input  1  forming a valid/ready handshake.
REQ-010 The block SHALL have port out_chan  output  2  source channel of out_data.
REQ-011 The block SHALL have port out_last  output  1  marks final byte of a packet.
REQ-012 The block SHALL have port timeout_err  output  1  one-cycle pulse on mid-packet starvation abort.

Function
REQ-013 Packet framing SHALL be: header byte, then LEN = header[5:2] payload bytes (LEN 0 = header only, packet 1..16 bytes).
REQ-014 FSM states SHALL be IDLE, XFER; no other states.
REQ-015 IDLE: if any (vldout & chan_en), grant the first such channel searching round-robin from last_grant+1 (wrap 2->0), enter XFER next cycle; else stay.
REQ-016 last_grant SHALL update only when a packet completes or aborts; after reset, search starts at channel 0.
REQ-017 XFER: read_enb[g] SHALL be 1 iff vldout[g] and output slot free (!out_valid or out_ready) and packet bytes remain; other read_enb bits 0.
REQ-018 A popped byte SHALL appear on out_data/out_valid/out_chan the following cycle (latency 1); out_valid SHALL hold with stable data until out_ready.
REQ-019 Popping with out_valid & out_ready in the same cycle SHALL sustain one byte per cycle throughput.
REQ-020 On the header pop, a 4-bit remaining counter SHALL load header[5:2]; each payload pop decrements it.
REQ-021 out_last SHALL be 1 on the byte popped when remaining is 0 after that pop (header when LEN 0).
REQ-022 After the last byte is popped, state SHALL return to IDLE; the next grant MAY begin the cycle after while out_last is still pending.
REQ-023 Clearing chan_en[g] during XFER SHALL NOT interrupt the current packet.
REQ-024 In XFER, a starvation counter SHALL count cycles with vldout[g]=0 and bytes remaining; it SHALL clear on any pop; stalls from out_ready=0 SHALL NOT count.
REQ-025 When starvation count reaches TIMEOUT_CYC, timeout_err SHALL pulse one cycle, the packet SHALL be abandoned (no out_last), state SHALL return to IDLE.

Reset
REQ-026 With rst_n low at a clock edge: state IDLE, last_grant 2, counters 0, read_enb 0, out_valid 0, out_data 0, out_chan 0, out_last 0, timeout_err 0.
REQ-027 Reset mid-packet SHALL discard any pending output byte with no further pops.

Structure
REQ-028 A shared package SHALL hold state encodings, channel-count constant (3), and the header LEN field position [5:2].
REQ-029 One sub-module rr_pick3 (combinational 3-way round-robin priority picker: request, last_grant -> grant, any) SHALL be used.

Verification
REQ-030 Ch1 holds header 0x08 (LEN 2) + 0xAA,0xBB, out_ready=1 -> out stream 0x08,0xAA,0xBB on consecutive cycles, out_chan=1, out_last only on 0xBB.
REQ-031 All three channels hold LEN-0 packets from reset -> grant order 0,1,2, then 0 again when ch0 refilled.
REQ-032 out_ready held 0 for 5 cycles mid-packet -> out_data stable, read_enb 0, no timeout_err.
REQ-033 Ch2 header 0x0C (LEN 3), vldout[2] drops after 1 payload for 16 cycles -> timeout_err pulse once, return to IDLE, ch0 next granted if pending.
REQ-034 chan_en=3'b101 with all vldout set -> channel 1 never granted; assert rst_n low mid-packet -> all outputs zero next cycle.
